// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential unsigned restoring divider. A rising edge on start latches the
// operands. One cycle is then spent checking for a zero divisor, followed by
// WIDTH restoring steps, MSB first. The results stay registered until the next
// accepted request.
//
// Ports
//   clk         : clock, rising-edge active
//   rst         : asynchronous, active-high reset
//   start       : request level; only a 0->1 transition seen in IDLE is accepted
//   dividend    : operand A (unsigned, WIDTH bits)
//   divisor     : operand B (unsigned, WIDTH bits)
//   quotient    : floor(A/B); all ones when B==0
//   remainder   : A mod B; A when B==0
//   busy        : high while in CHECK or CALC
//   done        : one-cycle pulse when the results become valid
//   div_by_zero : high when the last accepted division had B==0
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_CALC  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             start_q, start_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CW-1:0]    count_q, count_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   partial;
   logic             request;

   // The dividend register is shifted left during CALC, so its MSB is always
   // the next dividend bit to bring down into the partial remainder. The
   // partial remainder is one bit wider than the operands, so it can exceed
   // the divisor before the subtraction. After the subtraction the value is
   // below the divisor, so WIDTH bits are enough to hold it.
   always_comb begin
      state_d = state_q;
      start_d = start;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      count_d = count_q;
      dbz_d   = dbz_q;

      partial = {rem_q, dvd_q[WIDTH-1]};
      request = start && !start_q;

      case (state_q)
         S_IDLE: begin
            if (request) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               quot_d  = '0;
               rem_d   = '0;
               dbz_d   = 1'b0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (dvs_q == '0) begin
               quot_d  = '1;
               rem_d   = dvd_q;
               dbz_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               count_d = CW'(WIDTH - 1);
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            if (partial >= {1'b0, dvs_q}) begin
               rem_d  = WIDTH'(partial - {1'b0, dvs_q});
               quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d  = partial[WIDTH-1:0];
               quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
            if (count_q == '0) begin
               state_d = S_DONE;
            end else begin
               count_d = count_q - CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Reset aborts any division in progress. The start history is cleared, so a
   // start that is already high at the first edge after release counts as a
   // new request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         count_q <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         count_q <= count_d;
         dbz_q   <= dbz_d;
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign busy        = (state_q == S_CHECK) || (state_q == S_CALC);
   assign done        = (state_q == S_DONE);

endmodule
